uart_tx: RTL and testbench

Frame transmitter for the UART transmit path, the counterpart of the receive-side deserializer. It accepts a parallel byte on a one-cycle valid strobe and latches it together with the parity settings. It then shifts out a standard asynchronous frame, one bit per `CLK` cycle, on a registered serial line: start bit, data LSB first, optional parity bit, stop bit. `CLK` is the transmit bit-rate clock supplied by the clock-divider stage.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 63 ++++++
 tb/tb_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel request side and serial line of the frame transmitter
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic Data_Valid;
  logic PAR_EN;
  logic PAR_TYP;
  logic TX_OUT;
  logic Busy;
  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, Busy);
  modport slave (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: latches a byte and shifts out start, data LSB first, optional parity, stop
module uart_tx #(parameter int DATA_WIDTH = 8) (
  input logic CLK,
  input logic RST,
  uart_tx_if.slave tx
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] data_r;
  logic [CW-1:0] cnt, cnt_nx;
  logic par_en_r, par_typ_r;
  logic tx_r, tx_nx, busy_r, busy_nx;
  logic accept;
  assign accept = state == IDLE && tx.Data_Valid;
  // state register; line outputs are flopped from next-state values so they change with the state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
      tx_r <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      tx_r <= tx_nx;
      busy_r <= busy_nx;
    end
  end
  // frame contents are captured only on acceptance so later input changes cannot disturb the frame
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data_r <= '0;
      par_en_r <= 1'b0;
      par_typ_r <= 1'b0;
    end else if (accept) begin
      data_r <= tx.P_DATA;
      par_en_r <= tx.PAR_EN;
      par_typ_r <= tx.PAR_TYP;
    end
  end
  // next-state: requests are only seen in IDLE, STOP always returns to IDLE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = tx.Data_Valid ? START : IDLE;
      START: state_nx = DATA;
      DATA: state_nx = cnt != CW'(DATA_WIDTH - 1) ? DATA : par_en_r ? PARITY : STOP;
      PARITY: state_nx = STOP;
      default: state_nx = IDLE;
    endcase
  end
  // output decode for the coming cycle: bit index, line level and busy flag
  always_comb begin
    cnt_nx = state == DATA ? cnt + CW'(1) : '0;
    tx_nx = state_nx == START ? 1'b0 :
            state_nx == DATA ? data_r[cnt_nx] :
            state_nx == PARITY ? ^data_r ^ par_typ_r : 1'b1;
    busy_nx = state_nx != IDLE;
  end
  assign tx.TX_OUT = tx_r;
  assign tx.Busy = busy_r;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frames with a bit scoreboard plus hand-written corner sequences
module tb_uart_tx;
  logic CLK;
  logic RST;
  uart_tx_if #(.DATA_WIDTH(8)) u_if();
  uart_tx #(.DATA_WIDTH(8)) dut (.CLK(CLK), .RST(RST), .tx(u_if));

  typedef struct {
    logic [7:0] d;
    logic pe;
    logic pt;
    logic par;
    int len;
  } vec_t;

  vec_t vt[6];
  logic exp_q[$];
  int total = 0;
  int bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  // every busy cycle must carry the next scoreboard bit, every idle cycle a high line
  always @(negedge CLK) begin
    if (RST) begin
      if (u_if.Busy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bit: got %b want none", u_if.TX_OUT);
        end else check("tx_bit", {31'd0, u_if.TX_OUT}, {31'd0, exp_q.pop_front()});
      end else check("idle_line", {31'd0, u_if.TX_OUT}, 32'd1);
    end
  end

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic par, input int len);
    int n;
    @(negedge CLK);
    u_if.Data_Valid = 1'b1;
    u_if.P_DATA = d;
    u_if.PAR_EN = pe;
    u_if.PAR_TYP = pt;
    push_frame(d, pe, par);
    @(posedge CLK);
    #1;
    check("start_latency", {30'd0, u_if.Busy, u_if.TX_OUT}, 32'd2);
    u_if.Data_Valid = 1'b0;
    u_if.P_DATA = ~d;
    u_if.PAR_EN = ~pe;
    u_if.PAR_TYP = ~pt;
    n = 1;
    while (u_if.Busy && n < 40) begin
      @(posedge CLK);
      #1;
      if (u_if.Busy) n++;
    end
    check("busy_len", n, len);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, par: 1'b0, len: 11};
    vt[1] = '{d: 8'h00, pe: 1'b1, pt: 1'b1, par: 1'b1, len: 11};
    vt[2] = '{d: 8'hFF, pe: 1'b0, pt: 1'b0, par: 1'b0, len: 10};
    vt[3] = '{d: 8'h01, pe: 1'b1, pt: 1'b0, par: 1'b1, len: 11};
    vt[4] = '{d: 8'h7F, pe: 1'b1, pt: 1'b1, par: 1'b0, len: 11};
    vt[5] = '{d: 8'h55, pe: 1'b0, pt: 1'b1, par: 1'b0, len: 10};
    RST = 1'b0;
    u_if.Data_Valid = 1'b0;
    u_if.P_DATA = 8'h00;
    u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx", {31'd0, u_if.TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, u_if.Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    check("quiet_busy", {31'd0, u_if.Busy}, 32'd0);

    for (int i = 0; i < 6; i++) send(vt[i].d, vt[i].pe, vt[i].pt, vt[i].par, vt[i].len);

    // request during an active frame is dropped, inputs scrambled mid-frame
    fork
      send(8'h3C, 1'b1, 1'b1, 1'b1, 11);
      begin
        repeat (5) @(negedge CLK);
        u_if.Data_Valid = 1'b1;
        u_if.P_DATA = 8'h81;
        u_if.PAR_EN = 1'b0;
        @(negedge CLK);
        u_if.Data_Valid = 1'b0;
        u_if.P_DATA = 8'h99;
      end
    join
    repeat (3) @(negedge CLK);
    check("no_queued_request", {31'd0, u_if.Busy}, 32'd0);

    // one-cycle request only in the stop cycle is not accepted
    fork
      send(8'hFF, 1'b0, 1'b0, 1'b0, 10);
      begin
        repeat (11) @(negedge CLK);
        u_if.Data_Valid = 1'b1;
        u_if.P_DATA = 8'h81;
        @(negedge CLK);
        u_if.Data_Valid = 1'b0;
      end
    join
    repeat (3) @(negedge CLK);
    check("stop_cycle_ignored", {31'd0, u_if.Busy}, 32'd0);

    // held request: frames every 11 cycles with one idle cycle between
    @(negedge CLK);
    u_if.Data_Valid = 1'b1;
    u_if.P_DATA = 8'h55;
    u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0;
    repeat (3) push_frame(8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 34; k++) begin
      @(negedge CLK);
      check("b2b_busy", {31'd0, u_if.Busy}, {31'd0, k < 33 && k % 11 != 10});
      if (k == 31) u_if.Data_Valid = 1'b0;
    end
    check("b2b_drained", exp_q.size(), 0);

    // asynchronous reset during data bit 3
    @(negedge CLK);
    u_if.Data_Valid = 1'b1;
    u_if.P_DATA = 8'hF0;
    u_if.PAR_EN = 1'b0;
    push_frame(8'hF0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    u_if.Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("bit3_low", {30'd0, u_if.Busy, u_if.TX_OUT}, 32'd2);
    #2;
    RST = 1'b0;
    #1;
    check("async_tx", {31'd0, u_if.TX_OUT}, 32'd1);
    check("async_busy", {31'd0, u_if.Busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_reset_idle", {31'd0, u_if.Busy}, 32'd0);
    send(8'h12, 1'b1, 1'b0, 1'b0, 11);
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
